// File: rtl/obi_apb_bridge_multi.sv
// OBI subordinate to APB4 requestor bridge with NUM_SUB address windows.
// One transfer in flight; decode misses, PSLVERR and PREADY timeouts return as OBI errors.
module obi_apb_bridge_multi #(
   parameter int unsigned          ADDR_WIDTH     = 32,
   parameter int unsigned          DATA_WIDTH     = 32,
   parameter int unsigned          ID_WIDTH       = 1,
   parameter int unsigned          NUM_SUB        = 2,
   parameter int unsigned          SUB_ADDR_WIDTH = 8,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = '0,
   parameter int unsigned          TIMEOUT_CYCLES = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          obi_req_i,
   output logic                          obi_gnt_o,
   input  logic [ADDR_WIDTH-1:0]         obi_addr_i,
   input  logic                          obi_we_i,
   input  logic [DATA_WIDTH/8-1:0]       obi_be_i,
   input  logic [DATA_WIDTH-1:0]         obi_wdata_i,
   input  logic [ID_WIDTH-1:0]           obi_aid_i,
   output logic                          obi_rvalid_o,
   input  logic                          obi_rready_i,
   output logic [DATA_WIDTH-1:0]         obi_rdata_o,
   output logic [ID_WIDTH-1:0]           obi_rid_o,
   output logic                          obi_err_o,
   output logic [NUM_SUB-1:0]            apb_psel_o,
   output logic                          apb_penable_o,
   output logic                          apb_pwrite_o,
   output logic [2:0]                    apb_pprot_o,
   output logic [SUB_ADDR_WIDTH-1:0]     apb_paddr_o,
   output logic [DATA_WIDTH-1:0]         apb_pwdata_o,
   output logic [DATA_WIDTH/8-1:0]       apb_pstrb_o,
   input  logic [NUM_SUB-1:0]            apb_pready_i,
   input  logic [NUM_SUB*DATA_WIDTH-1:0] apb_prdata_i,
   input  logic [NUM_SUB-1:0]            apb_pslverr_i
);

   localparam int unsigned STRB_W = DATA_WIDTH / 8;
   localparam int unsigned IDX_W  = (NUM_SUB > 1) ? $clog2(NUM_SUB) : 1;
   localparam int unsigned CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [ADDR_WIDTH:0] WIN_END = (ADDR_WIDTH + 1)'(NUM_SUB) << SUB_ADDR_WIDTH;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_e;

   state_e                    state_q, state_d;
   logic [IDX_W-1:0]          idx_q, idx_d;
   logic [CNT_W-1:0]          cnt_q, cnt_d;
   logic [NUM_SUB-1:0]        psel_q, psel_d;
   logic                      penable_q, penable_d;
   logic                      pwrite_q, pwrite_d;
   logic [SUB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
   logic [DATA_WIDTH-1:0]     pwdata_q, pwdata_d;
   logic [STRB_W-1:0]         pstrb_q, pstrb_d;
   logic                      rvalid_q, rvalid_d;
   logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
   logic [ID_WIDTH-1:0]       rid_q, rid_d;
   logic                      err_q, err_d;

   logic [ADDR_WIDTH-1:0]     offset;
   logic                      miss;
   logic [CNT_W:0]            cnt_inc;
   logic                      timeout;
   logic                      sel_ready;
   logic                      sel_err;
   logic [DATA_WIDTH-1:0]     sel_rdata;

   // The grant is the only combinational output; reset masks it directly.
   assign obi_gnt_o = (state_q == IDLE) && obi_req_i && !rst;

   // NOTE: every signal written here gets a default first so no path leaves it unassigned (no latches).
   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      cnt_d     = cnt_q;
      psel_d    = psel_q;
      penable_d = penable_q;
      pwrite_d  = pwrite_q;
      paddr_d   = paddr_q;
      pwdata_d  = pwdata_q;
      pstrb_d   = pstrb_q;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;
      rid_d     = rid_q;
      err_d     = err_q;

      offset    = obi_addr_i - BASE_ADDR;
      miss      = {1'b0, offset} >= WIN_END;
      cnt_inc   = {1'b0, cnt_q} + (CNT_W + 1)'(1);
      timeout   = (TIMEOUT_CYCLES != 0) && (cnt_inc >= (CNT_W + 1)'(TIMEOUT_CYCLES));
      sel_ready = apb_pready_i[idx_q];
      sel_err   = apb_pslverr_i[idx_q];
      sel_rdata = apb_prdata_i[int'(idx_q) * DATA_WIDTH +: DATA_WIDTH];

      unique case (state_q)
         IDLE: begin
            if (obi_gnt_o) begin
               pwrite_d = obi_we_i;
               paddr_d  = offset[SUB_ADDR_WIDTH-1:0];
               pwdata_d = obi_wdata_i;
               pstrb_d  = obi_we_i ? obi_be_i : '0;
               rid_d    = obi_aid_i;
               idx_d    = IDX_W'(offset >> SUB_ADDR_WIDTH);
               if (miss) begin
                  state_d  = RESP;
                  rvalid_d = 1'b1;
                  rdata_d  = '0;
                  err_d    = 1'b1;
               end else begin
                  state_d = SETUP;
                  psel_d  = NUM_SUB'(1) << IDX_W'(offset >> SUB_ADDR_WIDTH);
                  cnt_d   = '0;
               end
            end
         end
         SETUP: begin
            state_d   = ACCESS;
            penable_d = 1'b1;
         end
         ACCESS: begin
            if (sel_ready || timeout) begin
               state_d   = RESP;
               psel_d    = '0;
               penable_d = 1'b0;
               rvalid_d  = 1'b1;
               rdata_d   = (sel_ready && !pwrite_q) ? sel_rdata : '0;
               err_d     = sel_ready ? sel_err : 1'b1;
            end else if (!cnt_inc[CNT_W]) begin
               cnt_d = cnt_inc[CNT_W-1:0];
            end
         end
         RESP: begin
            if (obi_rready_i) begin
               state_d  = IDLE;
               rvalid_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         idx_q     <= '0;
         cnt_q     <= '0;
         psel_q    <= '0;
         penable_q <= 1'b0;
         pwrite_q  <= 1'b0;
         paddr_q   <= '0;
         pwdata_q  <= '0;
         pstrb_q   <= '0;
         rvalid_q  <= 1'b0;
         rdata_q   <= '0;
         rid_q     <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         psel_q    <= psel_d;
         penable_q <= penable_d;
         pwrite_q  <= pwrite_d;
         paddr_q   <= paddr_d;
         pwdata_q  <= pwdata_d;
         pstrb_q   <= pstrb_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         rid_q     <= rid_d;
         err_q     <= err_d;
      end
   end

   assign obi_rvalid_o  = rvalid_q;
   assign obi_rdata_o   = rdata_q;
   assign obi_rid_o     = rid_q;
   assign obi_err_o     = err_q;
   assign apb_psel_o    = psel_q;
   assign apb_penable_o = penable_q;
   assign apb_pwrite_o  = pwrite_q;
   assign apb_pprot_o   = 3'b000;
   assign apb_paddr_o   = paddr_q;
   assign apb_pwdata_o  = pwdata_q;
   assign apb_pstrb_o   = pstrb_q;

endmodule

// File: tb/tb_obi_apb_bridge_multi.sv
// Scoreboard bench for obi_apb_bridge_multi: two APB subordinate models behind window base 0x1000.
module tb_obi_apb_bridge_multi;

   localparam int          AW   = 32;
   localparam int          DW   = 32;
   localparam int          NS   = 2;
   localparam int          SAW  = 8;
   localparam logic [31:0] BASE = 32'h1000;
   localparam int          TO   = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic           obi_req_i, obi_gnt_o, obi_we_i, obi_rready_i;
   logic [AW-1:0]  obi_addr_i;
   logic [3:0]     obi_be_i;
   logic [DW-1:0]  obi_wdata_i;
   logic [0:0]     obi_aid_i, obi_rid_o;
   logic           obi_rvalid_o, obi_err_o;
   logic [DW-1:0]  obi_rdata_o;
   logic [NS-1:0]  apb_psel_o, apb_pready_i, apb_pslverr_i;
   logic           apb_penable_o, apb_pwrite_o;
   logic [2:0]     apb_pprot_o;
   logic [SAW-1:0] apb_paddr_o;
   logic [DW-1:0]  apb_pwdata_o;
   logic [3:0]     apb_pstrb_o;
   logic [NS*DW-1:0] apb_prdata_i;

   obi_apb_bridge_multi #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(1), .NUM_SUB(NS),
      .SUB_ADDR_WIDTH(SAW), .BASE_ADDR(BASE), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst(rst),
      .obi_req_i(obi_req_i), .obi_gnt_o(obi_gnt_o), .obi_addr_i(obi_addr_i),
      .obi_we_i(obi_we_i), .obi_be_i(obi_be_i), .obi_wdata_i(obi_wdata_i),
      .obi_aid_i(obi_aid_i), .obi_rvalid_o(obi_rvalid_o), .obi_rready_i(obi_rready_i),
      .obi_rdata_o(obi_rdata_o), .obi_rid_o(obi_rid_o), .obi_err_o(obi_err_o),
      .apb_psel_o(apb_psel_o), .apb_penable_o(apb_penable_o), .apb_pwrite_o(apb_pwrite_o),
      .apb_pprot_o(apb_pprot_o), .apb_paddr_o(apb_paddr_o), .apb_pwdata_o(apb_pwdata_o),
      .apb_pstrb_o(apb_pstrb_o), .apb_pready_i(apb_pready_i), .apb_prdata_i(apb_prdata_i),
      .apb_pslverr_i(apb_pslverr_i)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int last_grant_cyc = 0;

   // Subordinate models: configurable wait states, read value, error flag, or never-ready.
   int          wait_cfg [NS];
   logic [31:0] rdval    [NS];
   logic        slverr_cfg [NS];
   logic        hang;
   int          acc_cnt;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst || !apb_penable_o) acc_cnt <= 0;
      else acc_cnt <= acc_cnt + 1;
   end

   always_comb begin
      apb_pready_i  = '0;
      apb_pslverr_i = '0;
      apb_prdata_i  = '0;
      for (int k = 0; k < NS; k++) begin
         apb_pready_i[k]          = apb_psel_o[k] & apb_penable_o & !hang & (acc_cnt >= wait_cfg[k]);
         apb_pslverr_i[k]         = slverr_cfg[k];
         apb_prdata_i[k*DW +: DW] = rdval[k];
      end
   end

   typedef struct packed {
      logic [31:0] rdata;
      logic [0:0]  rid;
      logic        err;
   } resp_t;
   resp_t sb[$];

   // R-channel scoreboard: every handshake pops the oldest expected response.
   always @(negedge clk) begin
      if (!rst && obi_rvalid_o && obi_rready_i) begin
         resp_t got, exp;
         got = '{obi_rdata_o, obi_rid_o, obi_err_o};
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL r_unexpected got rdata=%h rid=%0d err=%0b", got.rdata, got.rid, got.err);
         end else begin
            exp = sb.pop_front();
            if (got !== exp) begin
               errors++;
               $display("FAIL r_response got rdata=%h rid=%0d err=%0b want rdata=%h rid=%0d err=%0b",
                        got.rdata, got.rid, got.err, exp.rdata, exp.rid, exp.err);
            end
         end
      end
   end

   // One complete OBI transaction with APB-phase, latency and backpressure checks.
   task automatic run_txn(input logic [31:0] addr, input logic we, input logic [3:0] be,
                          input logic [31:0] wdata, input logic [0:0] aid, input int hold,
                          input string name);
      logic [31:0] off;
      logic        hit;
      int          idx, exp_n, n;
      resp_t       exp;
      off   = addr - BASE;
      hit   = off < 32'(NS << SAW);
      idx   = int'(off[SAW]);
      exp.rid   = aid;
      exp.err   = !hit || hang || slverr_cfg[idx];
      exp.rdata = (hit && !hang && !we) ? rdval[idx] : 32'h0;
      exp_n = !hit ? 0 : (hang ? 1 + TO : 2 + wait_cfg[idx]);

      obi_rready_i = (hold == 0);
      obi_req_i = 1'b1; obi_addr_i = addr; obi_we_i = we;
      obi_be_i = be; obi_wdata_i = wdata; obi_aid_i = aid;
      #1;
      checks++;
      if (obi_gnt_o !== 1'b1) begin
         errors++; $display("FAIL %s_gnt got %b want 1", name, obi_gnt_o);
      end
      @(posedge clk);
      last_grant_cyc = cyc;
      #1;
      obi_req_i = 1'b0; obi_addr_i = $urandom; obi_we_i = ~we;
      obi_be_i = ~be; obi_wdata_i = $urandom; obi_aid_i = ~aid;
      sb.push_back(exp);

      n = 0;
      while (!obi_rvalid_o && n < 50) begin
         checks++;
         if (hit) begin
            if (apb_psel_o !== NS'(1 << idx) || apb_penable_o !== (n > 0) ||
                apb_paddr_o !== off[SAW-1:0] || apb_pwrite_o !== we || apb_pwdata_o !== wdata ||
                apb_pstrb_o !== (we ? be : 4'h0) || apb_pprot_o !== 3'b000) begin
               errors++;
               $display("FAIL %s_apb cyc%0d got psel=%b pen=%b paddr=%h pw=%b pwdata=%h pstrb=%h want psel=%b pen=%b paddr=%h pw=%b pwdata=%h pstrb=%h",
                        name, n, apb_psel_o, apb_penable_o, apb_paddr_o, apb_pwrite_o, apb_pwdata_o,
                        apb_pstrb_o, NS'(1 << idx), (n > 0), off[SAW-1:0], we, wdata, (we ? be : 4'h0));
            end
         end else if (apb_psel_o !== '0) begin
            errors++; $display("FAIL %s_miss_psel got %b want 00", name, apb_psel_o);
         end
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (n !== exp_n) begin
         errors++; $display("FAIL %s_latency got %0d want %0d", name, n + 1, exp_n + 1);
      end
      checks++;
      if (apb_psel_o !== '0 || apb_penable_o !== 1'b0) begin
         errors++; $display("FAIL %s_apb_idle got psel=%b pen=%b want 0", name, apb_psel_o, apb_penable_o);
      end

      obi_req_i = (hold > 0);
      for (int i = 0; i < hold; i++) begin
         #1;
         checks++;
         if (obi_rvalid_o !== 1'b1 || obi_gnt_o !== 1'b0 || obi_rdata_o !== exp.rdata ||
             obi_rid_o !== exp.rid || obi_err_o !== exp.err) begin
            errors++;
            $display("FAIL %s_hold%0d got rvalid=%b gnt=%b rdata=%h rid=%0d err=%b want 1 0 %h %0d %b",
                     name, i, obi_rvalid_o, obi_gnt_o, obi_rdata_o, obi_rid_o, obi_err_o,
                     exp.rdata, exp.rid, exp.err);
         end
         @(posedge clk); #1;
      end
      obi_req_i = 1'b0;
      obi_rready_i = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (obi_rvalid_o !== 1'b0) begin
         errors++; $display("FAIL %s_rvalid_drop got %b want 0", name, obi_rvalid_o);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; obi_req_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         checks++;
         if (obi_gnt_o !== 1'b0 || apb_psel_o !== '0 || obi_rvalid_o !== 1'b0 || apb_penable_o !== 1'b0 ||
             obi_rdata_o !== '0 || obi_err_o !== 1'b0 || apb_paddr_o !== '0 || apb_pstrb_o !== '0) begin
            errors++;
            $display("FAIL reset_outputs got gnt=%b psel=%b rvalid=%b pen=%b rdata=%h err=%b want all 0",
                     obi_gnt_o, apb_psel_o, obi_rvalid_o, apb_penable_o, obi_rdata_o, obi_err_o);
         end
      end
      rst = 1'b0;
      #1;
      checks++;
      if (obi_gnt_o !== 1'b1) begin
         errors++; $display("FAIL reset_release_gnt got %b want 1", obi_gnt_o);
      end
      obi_req_i = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_read;
      rdval[1] = 32'hCAFE_F00D;
      run_txn(32'h1104, 1'b0, 4'hF, 32'h1234_5678, 1'b1, 0, "read0ws");
   endtask

   task automatic test_write_backpressure;
      wait_cfg[0] = 3;
      run_txn(32'h1008, 1'b1, 4'b0011, 32'hA5A5_5A5A, 1'b0, 2, "write3ws");
      wait_cfg[0] = 0;
   endtask

   task automatic test_decode_miss;
      run_txn(32'h0FFC, 1'b0, 4'hF, 32'h0, 1'b1, 0, "miss_low");
      run_txn(32'h1200, 1'b0, 4'hF, 32'h0, 1'b0, 0, "miss_high");
      rdval[1] = 32'h0BAD_CAFE;
      run_txn(32'h11FF, 1'b0, 4'hF, 32'h0, 1'b1, 0, "last_hit");
   endtask

   task automatic test_errors;
      slverr_cfg[0] = 1'b1;
      run_txn(32'h1010, 1'b0, 4'hF, 32'h0, 1'b0, 0, "pslverr");
      slverr_cfg[0] = 1'b0;
      slverr_cfg[1] = 1'b1;
      rdval[0] = 32'h5555_AAAA;
      run_txn(32'h1020, 1'b0, 4'hF, 32'h0, 1'b1, 0, "other_pslverr");
      slverr_cfg[1] = 1'b0;
      hang = 1'b1;
      run_txn(32'h1100, 1'b0, 4'hF, 32'h0, 1'b1, 1, "timeout");
      hang = 1'b0;
   endtask

   task automatic test_back_to_back;
      int prev;
      for (int i = 0; i < 6; i++) begin
         rdval[0] = $urandom; rdval[1] = $urandom;
         wait_cfg[0] = 0; wait_cfg[1] = 0;
         prev = last_grant_cyc;
         run_txn(BASE + ($urandom_range(0, 127) << 2), 1'($urandom), 4'($urandom), $urandom,
                 1'($urandom), 0, "b2b");
         if (i > 0) begin
            checks++;
            if (last_grant_cyc - prev !== 4) begin
               errors++; $display("FAIL b2b_throughput got %0d want 4", last_grant_cyc - prev);
            end
         end
      end
   endtask

   task automatic test_reset_mid;
      hang = 1'b1;
      obi_req_i = 1'b1; obi_addr_i = 32'h1040; obi_we_i = 1'b1;
      obi_be_i = 4'hF; obi_wdata_i = 32'hDEAD_BEEF; obi_aid_i = 1'b0;
      @(posedge clk); #1;
      obi_req_i = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      hang = 1'b0;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (apb_psel_o !== '0 || apb_penable_o !== 1'b0 || obi_rvalid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid cyc%0d got psel=%b pen=%b rvalid=%b want 0 0 0",
                     i, apb_psel_o, apb_penable_o, obi_rvalid_o);
         end
         @(posedge clk); #1;
      end
      rdval[0] = 32'h7777_0001;
      run_txn(32'h1044, 1'b0, 4'hF, 32'h0, 1'b1, 0, "after_reset");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; hang = 1'b0; obi_req_i = 1'b0; obi_rready_i = 1'b1;
      obi_addr_i = '0; obi_we_i = 1'b0; obi_be_i = '0; obi_wdata_i = '0; obi_aid_i = '0;
      for (int k = 0; k < NS; k++) begin
         wait_cfg[k] = 0; rdval[k] = '0; slverr_cfg[k] = 1'b0;
      end
      #1;
      test_reset();
      test_read();
      test_write_backpressure();
      test_decode_miss();
      test_errors();
      test_back_to_back();
      test_reset_mid();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (sb.size() != 0) begin
         errors++; $display("FAIL scoreboard_drain got %0d pending want 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
